// File: rtl/em_tag_encoder.sv
// EM4100-family tag emulator: frames a parity-protected ID and streams it
// as Manchester or biphase symbols with a start/busy/done handshake.
module em_tag_encoder #(
    parameter int DATA_BITS   = 40,
    parameter int HEADER_BITS = 9,
    parameter int BIT_PERIOD  = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 mode,
    input  logic [7:0]           repeat_count,
    input  logic [DATA_BITS-1:0] data,
    output logic                 busy,
    output logic                 done,
    output logic                 q,
    output logic                 q_en
);
    localparam int NIBBLES    = DATA_BITS / 4;
    localparam int FRAME_BITS = HEADER_BITS + 5 * NIBBLES + 5;
    localparam int BW         = $clog2(FRAME_BITS);
    localparam int PW         = $clog2(BIT_PERIOD);

    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);
    localparam logic [PW-1:0] LAST_PER = PW'(BIT_PERIOD - 1);
    localparam logic [PW-1:0] HALF     = PW'(BIT_PERIOD / 2);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    logic [1:0]           state;
    logic [DATA_BITS-1:0] data_r;
    logic                 mode_r;
    logic                 cont_r;
    logic [7:0]           frames_left;
    logic                 stop_pend;
    logic [BW-1:0]        bit_cnt;
    logic [PW-1:0]        per_cnt;
    logic                 level;

    // Frame vector, index 0 is the first bit on the line.
    logic [FRAME_BITS-1:0] frame;
    logic [3:0]            nib;
    logic [3:0]            col;

    always_comb begin
        frame = '0;
        nib   = '0;
        col   = '0;
        for (int i = 0; i < HEADER_BITS; i++)
            frame[i] = 1'b1;
        for (int r = 0; r < NIBBLES; r++) begin
            nib = data_r[DATA_BITS-1-4*r -: 4];
            for (int k = 0; k < 4; k++)
                frame[HEADER_BITS + 5*r + k] = nib[3-k];
            frame[HEADER_BITS + 5*r + 4] = ^nib;
            col = col ^ nib;
        end
        for (int j = 0; j < 4; j++)
            frame[HEADER_BITS + 5*NIBBLES + j] = col[3-j];
    end

    logic          per_wrap;
    logic          frame_end;
    logic          last_frame;
    logic [PW-1:0] per_nxt;
    logic [BW-1:0] bit_nxt;
    logic          b_nxt;
    logic          lvl_nxt;
    logic          q_nxt;

    always_comb begin
        per_wrap   = (per_cnt == LAST_PER);
        frame_end  = per_wrap && (bit_cnt == LAST_BIT);
        per_nxt    = per_wrap ? '0 : per_cnt + 1'b1;
        bit_nxt    = per_wrap ? (frame_end ? '0 : bit_cnt + 1'b1) : bit_cnt;
        b_nxt      = frame[bit_nxt];
        lvl_nxt    = level ^ ((per_nxt == '0) || ((per_nxt == HALF) && !b_nxt));
        q_nxt      = mode_r ? lvl_nxt : (b_nxt ^ (per_nxt >= HALF));
        last_frame = cont_r ? (stop_pend || stop) : (frames_left == 8'd1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            data_r      <= '0;
            mode_r      <= 1'b0;
            cont_r      <= 1'b0;
            frames_left <= '0;
            stop_pend   <= 1'b0;
            bit_cnt     <= '0;
            per_cnt     <= '0;
            level       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            q           <= 1'b0;
            q_en        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, FIN: begin
                    stop_pend <= 1'b0;
                    if (start) begin
                        data_r      <= data;
                        mode_r      <= mode;
                        cont_r      <= (repeat_count == 8'd0);
                        frames_left <= repeat_count;
                        bit_cnt     <= '0;
                        per_cnt     <= '0;
                        // First symbol is a header 1: Manchester high half, biphase level 0->1.
                        level       <= 1'b1;
                        q           <= 1'b1;
                        q_en        <= 1'b1;
                        busy        <= 1'b1;
                        state       <= SEND;
                    end else begin
                        state <= IDLE;
                    end
                end
                SEND: begin
                    if (cont_r && stop)
                        stop_pend <= 1'b1;
                    if (frame_end && last_frame) begin
                        state   <= FIN;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        q_en    <= 1'b0;
                        q       <= 1'b0;
                        level   <= 1'b0;
                        bit_cnt <= '0;
                        per_cnt <= '0;
                    end else begin
                        per_cnt <= per_nxt;
                        bit_cnt <= bit_nxt;
                        level   <= lvl_nxt;
                        q       <= q_nxt;
                        if (frame_end && !cont_r)
                            frames_left <= frames_left - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_em_tag_encoder.sv
// Directed bench for em_tag_encoder at BIT_PERIOD=4 with hand-built frames.
module tb_em_tag_encoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        mode = 1'b0;
    logic [7:0]  repeat_count = 8'd0;
    logic [39:0] data = '0;
    logic        busy, done, q, q_en;

    int checks = 0;
    int fails  = 0;
    int n;

    // Frames MSB-first: bit 63 is the first bit on the line.
    localparam logic [63:0] FR_ZERO = 64'hFF80_0000_0000_0000;
    localparam logic [63:0] FR_F0   = 64'hFFF8_0000_0000_001E;
    localparam logic [63:0] FR_ONE  = 64'hFF80_0000_0000_0062;

    always #5 clk = ~clk;

    em_tag_encoder #(.DATA_BITS(40), .HEADER_BITS(9), .BIT_PERIOD(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
        .repeat_count(repeat_count), .data(data),
        .busy(busy), .done(done), .q(q), .q_en(q_en)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the first transmit cycle.
    task automatic do_start(input logic [39:0] d, input logic m, input logic [7:0] rc);
        data = d; mode = m; repeat_count = rc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_frame(input logic [63:0] fr, input logic m, input string tag);
        logic lvl;
        logic b;
        logic e;
        lvl = 1'b0;
        for (int i = 0; i < 64; i++) begin
            b = fr[63-i];
            for (int p = 0; p < 4; p++) begin
                if (m) begin
                    if (p == 0) lvl = ~lvl;
                    if (p == 2 && !b) lvl = ~lvl;
                    e = lvl;
                end else begin
                    e = (p < 2) ? b : ~b;
                end
                chk($sformatf("%s_q_b%0d_p%0d", tag, i, p), q, e);
                if (p == 0) begin
                    chk($sformatf("%s_qen_b%0d", tag, i), q_en, 1'b1);
                    chk($sformatf("%s_busy_b%0d", tag, i), busy, 1'b1);
                    chk($sformatf("%s_done_b%0d", tag, i), done, 1'b0);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic check_end(input string tag);
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_qen"},  q_en, 1'b0);
        chk({tag, "_q"},    q,    1'b0);
    endtask

    task automatic run_count(input int stop_at, input int start_at, output int cnt);
        cnt = 0;
        while (q_en === 1'b1 && cnt < 5000) begin
            stop  = (cnt == stop_at);
            start = (cnt == start_at);
            cnt++;
            @(negedge clk);
        end
        stop  = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_q", q, 1'b0);
        chk("rst_qen", q_en, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // All-zero Manchester, single frame.
        do_start(40'h0, 1'b0, 8'd1);
        check_frame(FR_ZERO, 1'b0, "zero");
        check_end("zero_end");

        // Back-to-back start in the done cycle: parity frame.
        do_start(40'hF0_0000_0000, 1'b0, 8'd1);
        check_frame(FR_F0, 1'b0, "par");
        check_end("par_end");
        @(negedge clk);
        chk("par_done_clear", done, 1'b0);
        chk("par_idle_busy", busy, 1'b0);

        // Biphase with a single 1 in the LSB.
        do_start(40'h00_0000_0001, 1'b1, 8'd1);
        chk("bp_first_level", q, 1'b1);
        check_frame(FR_ONE, 1'b1, "bp");
        check_end("bp_end");
        @(negedge clk);

        // Same payload Manchester.
        do_start(40'h00_0000_0001, 1'b0, 8'd1);
        check_frame(FR_ONE, 1'b0, "m1");
        check_end("m1_end");
        @(negedge clk);

        // Three frames; inputs changed and start pulsed while busy.
        do_start(40'h0, 1'b0, 8'd3);
        data = 40'hFF_FFFF_FFFF; mode = 1'b1; repeat_count = 8'd1;
        run_count(-1, 50, n);
        chk("rep3_len", n, 768);
        check_end("rep3_end");
        @(negedge clk);

        // Continuous, stop mid frame 2.
        do_start(40'h0, 1'b0, 8'd0);
        run_count(300, -1, n);
        chk("cont_mid_len", n, 512);
        check_end("cont_mid_end");
        @(negedge clk);

        // Continuous, stop on the last cycle of frame 1.
        do_start(40'h0, 1'b0, 8'd0);
        run_count(255, -1, n);
        chk("cont_last_len", n, 256);
        check_end("cont_last_end");
        @(negedge clk);

        // stop ignored when a repeat count is given.
        do_start(40'h0, 1'b0, 8'd2);
        run_count(10, -1, n);
        chk("rep2_stop_len", n, 512);
        check_end("rep2_end");
        @(negedge clk);

        // Reset at cycle 100 of a frame.
        do_start(40'hF0_0000_0000, 1'b0, 8'd1);
        repeat (99) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_qen", q_en, 1'b0);
        chk("mrst_q", q, 1'b0);
        chk("mrst_done", done, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_done2", done, 1'b0);
        do_start(40'hF0_0000_0000, 1'b0, 8'd1);
        check_frame(FR_F0, 1'b0, "post");
        check_end("post_end");
        @(negedge clk);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
